// File: rtl/pcpi_arb_pkg.sv
// rtl/pcpi_arb_pkg.sv - shared types and defaults for the PCPI share arbiter
//
// Contents:
//   arb_state_t     : arbiter FSM state (IDLE / ISSUE / RESP)
//   req_idx_t       : requester index (two requesters, one bit)
//   PCPI_ARB_XLEN   : default data/instruction width
//   PCPI_ARB_TIMEOUT: default no-wait timeout in issue cycles
//   idx_onehot()    : requester index to two-bit one-hot

package pcpi_arb_pkg;

    localparam int PCPI_ARB_XLEN    = 32;
    localparam int PCPI_ARB_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_t;

    typedef logic req_idx_t;

    function automatic logic [1:0] idx_onehot(input req_idx_t idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/pcpi_rr_pick.sv
// rtl/pcpi_rr_pick.sv - combinational two-way round-robin picker
//
// Ports:
//   req_valid  in  2 : per-requester request valid
//   last_grant in  1 : requester granted most recently
//   grant      out 2 : one-hot grant, zero when nobody requests
//   grant_idx  out 1 : index of the granted requester (0 when nobody requests)

module pcpi_rr_pick
    import pcpi_arb_pkg::*;
(
    input  logic [1:0] req_valid,
    input  req_idx_t   last_grant,
    output logic [1:0] grant,
    output req_idx_t   grant_idx
);

    always_comb begin
        grant_idx = 1'b0;
        grant     = 2'b00;
        if (req_valid == 2'b11) begin
            // Contention: the requester that did not win last time goes next.
            grant_idx = ~last_grant;
        end else if (req_valid[1]) begin
            grant_idx = 1'b1;
        end
        if (req_valid != 2'b00) begin
            grant = idx_onehot(grant_idx);
        end
    end

endmodule

// File: rtl/pcpi_share_arbiter.sv
// rtl/pcpi_share_arbiter.sv - shares one PCPI coprocessor port between two requesters
//
// Ports:
//   clk, rst_n                  : clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready [1:0]   : per-requester handshake, ready only while idle
//   req_insn/rs1/rs2 [2*XLEN]   : requester r in bits [r*XLEN +: XLEN]
//   rsp_valid [1:0]             : one-cycle response pulse to the issuing requester
//   rsp_rd, rsp_wr, rsp_err     : shared result, writeback flag, timeout flag
//   pcpi_valid/insn/rs1/rs2     : registered PCPI request, held until completion
//   pcpi_wr/rd/wait/ready       : PCPI coprocessor status and result

module pcpi_share_arbiter
    import pcpi_arb_pkg::*;
#(
    parameter int XLEN    = PCPI_ARB_XLEN,
    parameter int TIMEOUT = PCPI_ARB_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2*XLEN-1:0] req_insn,
    input  logic [2*XLEN-1:0] req_rs1,
    input  logic [2*XLEN-1:0] req_rs2,
    output logic [1:0]        rsp_valid,
    output logic [XLEN-1:0]   rsp_rd,
    output logic              rsp_wr,
    output logic              rsp_err,
    output logic              pcpi_valid,
    output logic [XLEN-1:0]   pcpi_insn,
    output logic [XLEN-1:0]   pcpi_rs1,
    output logic [XLEN-1:0]   pcpi_rs2,
    input  logic              pcpi_wr,
    input  logic [XLEN-1:0]   pcpi_rd,
    input  logic              pcpi_wait,
    input  logic              pcpi_ready
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);

    arb_state_t    state;
    req_idx_t      owner;
    req_idx_t      last_grant;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] cnt_inc;
    logic          timeout_hit;

    logic [1:0]    pick_grant;
    req_idx_t      pick_idx;

    pcpi_rr_pick u_pick (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .grant_idx  (pick_idx)
    );

    // Gating with rst_n keeps req_ready low for the whole reset window even
    // though the FSM already sits in IDLE.
    assign req_ready = (state == ST_IDLE && rst_n) ? pick_grant : 2'b00;

    assign cnt_inc     = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CW'(1);
    assign timeout_hit = (cnt_inc >= CNT_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            wait_cnt   <= '0;
            pcpi_valid <= 1'b0;
            pcpi_insn  <= '0;
            pcpi_rs1   <= '0;
            pcpi_rs2   <= '0;
            rsp_valid  <= 2'b00;
            rsp_rd     <= '0;
            rsp_wr     <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            rsp_valid <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if ((req_valid & req_ready) != 2'b00) begin
                        pcpi_insn  <= pick_idx ? req_insn[2*XLEN-1:XLEN] : req_insn[XLEN-1:0];
                        pcpi_rs1   <= pick_idx ? req_rs1[2*XLEN-1:XLEN]  : req_rs1[XLEN-1:0];
                        pcpi_rs2   <= pick_idx ? req_rs2[2*XLEN-1:XLEN]  : req_rs2[XLEN-1:0];
                        owner      <= pick_idx;
                        last_grant <= pick_idx;
                        pcpi_valid <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // A completion in the same cycle as the timeout still
                    // counts as a normal completion.
                    if (pcpi_ready) begin
                        rsp_rd     <= pcpi_wr ? pcpi_rd : '0;
                        rsp_wr     <= pcpi_wr;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= idx_onehot(owner);
                        pcpi_valid <= 1'b0;
                        state      <= ST_RESP;
                    end else if (pcpi_wait) begin
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= cnt_inc;
                        if (timeout_hit) begin
                            rsp_rd     <= '0;
                            rsp_wr     <= 1'b0;
                            rsp_err    <= 1'b1;
                            rsp_valid  <= idx_onehot(owner);
                            pcpi_valid <= 1'b0;
                            state      <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcpi_share_arbiter.sv
// tb/tb_pcpi_share_arbiter.sv - directed self-checking bench for pcpi_share_arbiter

module tb_pcpi_share_arbiter;

    localparam int XLEN = 32;

    logic              clk;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [2*XLEN-1:0] req_insn;
    logic [2*XLEN-1:0] req_rs1;
    logic [2*XLEN-1:0] req_rs2;
    logic [1:0]        rsp_valid;
    logic [XLEN-1:0]   rsp_rd;
    logic              rsp_wr;
    logic              rsp_err;
    logic              pcpi_valid;
    logic [XLEN-1:0]   pcpi_insn;
    logic [XLEN-1:0]   pcpi_rs1;
    logic [XLEN-1:0]   pcpi_rs2;
    logic              pcpi_wr;
    logic [XLEN-1:0]   pcpi_rd;
    logic              pcpi_wait;
    logic              pcpi_ready;

    int checks = 0;
    int errors = 0;

    pcpi_share_arbiter #(.XLEN(XLEN), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_insn   (req_insn),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .rsp_valid  (rsp_valid),
        .rsp_rd     (rsp_rd),
        .rsp_wr     (rsp_wr),
        .rsp_err    (rsp_err),
        .pcpi_valid (pcpi_valid),
        .pcpi_insn  (pcpi_insn),
        .pcpi_rs1   (pcpi_rs1),
        .pcpi_rs2   (pcpi_rs2),
        .pcpi_wr    (pcpi_wr),
        .pcpi_rd    (pcpi_rd),
        .pcpi_wait  (pcpi_wait),
        .pcpi_ready (pcpi_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        req_valid  = 2'b00;
        req_insn   = '0;
        req_rs1    = '0;
        req_rs2    = '0;
        pcpi_wr    = 1'b0;
        pcpi_rd    = '0;
        pcpi_wait  = 1'b0;
        pcpi_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_wr, rsp_err, pcpi_valid} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0000000",
                     {req_ready, rsp_valid, rsp_wr, rsp_err, pcpi_valid});
        end
        checks++;
        if ({rsp_rd, pcpi_insn, pcpi_rs1, pcpi_rs2} !== '0) begin
            errors++;
            $display("FAIL reset_data: rd=%h insn=%h rs1=%h rs2=%h required all 0",
                     rsp_rd, pcpi_insn, pcpi_rs1, pcpi_rs2);
        end
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_contention();
        logic [XLEN-1:0] insn_of [2];
        logic [1:0]      oh;
        insn_of[0] = 32'h0000_0100;
        insn_of[1] = 32'h0000_0200;
        req_insn   = {insn_of[1], insn_of[0]};
        req_rs1    = {32'd21, 32'd11};
        req_rs2    = {32'd22, 32'd12};
        pcpi_ready = 1'b1;
        pcpi_wr    = 1'b1;
        pcpi_rd    = 32'h77;
        req_valid  = 2'b11;
        for (int i = 0; i < 4; i++) begin
            oh = (i % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            checks++;
            if (req_ready !== oh) begin
                errors++;
                $display("FAIL contention_grant[%0d]: got %b required %b", i, req_ready, oh);
            end
            tick();
            checks++;
            if (pcpi_valid !== 1'b1 || pcpi_insn !== insn_of[i % 2]) begin
                errors++;
                $display("FAIL contention_insn[%0d]: valid=%b insn=%h required 1 %h",
                         i, pcpi_valid, pcpi_insn, insn_of[i % 2]);
            end
            tick();
            checks++;
            if (rsp_valid !== oh || rsp_rd !== 32'h77) begin
                errors++;
                $display("FAIL contention_rsp[%0d]: rsp_valid=%b rd=%h required %b 77",
                         i, rsp_valid, rsp_rd, oh);
            end
            if (i == 3) req_valid = 2'b00;
            tick();
        end
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int lat;
        req_insn  = {32'h0, 32'h0200_000B};
        req_rs1   = {32'h0, 32'd3};
        req_rs2   = {32'h0, 32'd5};
        req_valid = 2'b01;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_ready: got %b required 01", req_ready);
        end
        tick();
        lat = 1;
        req_valid = 2'b00;
        checks++;
        if (pcpi_valid !== 1'b1 || pcpi_insn !== 32'h0200_000B || pcpi_rs1 !== 32'd3 ||
            pcpi_rs2 !== 32'd5 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL single_issue: valid=%b insn=%h rs1=%h rs2=%h ready=%b required 1 0200000b 3 5 00",
                     pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, req_ready);
        end
        tick();
        lat++;
        pcpi_ready = 1'b1;
        pcpi_wr    = 1'b1;
        pcpi_rd    = 32'd15;
        while (rsp_valid === 2'b00 && lat < 10) begin
            tick();
            lat++;
            pcpi_ready = 1'b0;
        end
        pcpi_wr = 1'b0;
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL single_latency: got %0d required 3", lat);
        end
        checks++;
        if (rsp_valid !== 2'b01 || rsp_rd !== 32'd15 || rsp_wr !== 1'b1 ||
            rsp_err !== 1'b0 || pcpi_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp: rsp_valid=%b rd=%0d wr=%b err=%b pvalid=%b required 01 15 1 0 0",
                     rsp_valid, rsp_rd, rsp_wr, rsp_err, pcpi_valid);
        end
        tick();
        checks++;
        if (rsp_valid !== 2'b00 || rsp_rd !== 32'd15) begin
            errors++;
            $display("FAIL single_hold: rsp_valid=%b rd=%0d required 00 15", rsp_valid, rsp_rd);
        end
    endtask

    task automatic test_long_wait();
        int n;
        req_insn  = {32'h0000_0ABC, 32'h0};
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        pcpi_wait = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (pcpi_valid === 1'b1) n++;
            tick();
        end
        pcpi_wait  = 1'b0;
        pcpi_ready = 1'b1;
        pcpi_wr    = 1'b1;
        pcpi_rd    = 32'h1234;
        if (pcpi_valid === 1'b1) n++;
        tick();
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
        checks++;
        if (n !== 41) begin
            errors++;
            $display("FAIL long_wait_cycles: got %0d required 41", n);
        end
        checks++;
        if (rsp_valid !== 2'b10 || rsp_err !== 1'b0 || rsp_rd !== 32'h1234 || pcpi_valid !== 1'b0) begin
            errors++;
            $display("FAIL long_wait_rsp: rsp_valid=%b err=%b rd=%h pvalid=%b required 10 0 1234 0",
                     rsp_valid, rsp_err, rsp_rd, pcpi_valid);
        end
        tick();
    endtask

    task automatic test_timeout();
        int n;
        req_insn  = {32'h0, 32'h0000_DEAD};
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        n = 0;
        while (pcpi_valid === 1'b1 && n < 30) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d required 16", n);
        end
        checks++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_rd !== 32'h0 || rsp_wr !== 1'b0) begin
            errors++;
            $display("FAIL timeout_rsp: rsp_valid=%b err=%b rd=%h wr=%b required 01 1 0 0",
                     rsp_valid, rsp_err, rsp_rd, rsp_wr);
        end
        tick();
    endtask

    task automatic test_ready_at_timeout();
        int n;
        req_insn  = {32'h0, 32'h0000_BEEF};
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        n = 1;
        for (int i = 0; i < 15; i++) begin
            if (pcpi_valid === 1'b1) n++;
            tick();
        end
        checks++;
        if (n !== 16 || pcpi_valid !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_issue: cycles=%0d pvalid=%b required 16 1", n, pcpi_valid);
        end
        pcpi_ready = 1'b1;
        pcpi_wr    = 1'b0;
        pcpi_rd    = 32'h5555;
        tick();
        pcpi_ready = 1'b0;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_wr !== 1'b0 || rsp_rd !== 32'h0) begin
            errors++;
            $display("FAIL same_cycle_rsp: rsp_valid=%b err=%b wr=%b rd=%h required 01 0 0 0",
                     rsp_valid, rsp_err, rsp_wr, rsp_rd);
        end
        tick();
    endtask

    task automatic test_reset_mid_issue();
        int seen;
        req_insn  = {32'h0000_0F01, 32'h0000_0F0F};
        req_rs1   = {32'd8, 32'd7};
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_wr, rsp_err, pcpi_valid} !== 7'b0 ||
            {rsp_rd, pcpi_insn, pcpi_rs1, pcpi_rs2} !== '0) begin
            errors++;
            $display("FAIL reset_async: ctrl=%b insn=%h rs1=%h rd=%h required all 0",
                     {req_ready, rsp_valid, rsp_wr, rsp_err, pcpi_valid}, pcpi_insn, pcpi_rs1, rsp_rd);
        end
        tick();
        tick();
        #2 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid !== 2'b00 || pcpi_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_no_rsp: active cycles=%0d required 0", seen);
        end
        req_valid = 2'b11;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL reset_next_grant: got %b required 01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        checks++;
        if (pcpi_insn !== 32'h0000_0F0F || pcpi_rs1 !== 32'd7) begin
            errors++;
            $display("FAIL reset_next_insn: insn=%h rs1=%0d required 00000f0f 7", pcpi_insn, pcpi_rs1);
        end
        pcpi_ready = 1'b1;
        tick();
        pcpi_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_long_wait();
        test_timeout();
        test_ready_at_timeout();
        test_reset_mid_issue();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
